// File: rtl/cnn_conv_sched.sv
// 3x3 valid-convolution scheduler for CNN_16: loads the kernel, then sequences
// tap reads, MAC strobes and result writes for every output pixel.
module cnn_conv_sched #(
  parameter int          IMG_W = 16,
  parameter int          IMG_H = 16,
  parameter logic [11:0] KBASE = 12'h000,
  parameter logic [11:0] IBASE = 12'h100,
  parameter logic [11:0] OBASE = 12'h200
) (
  input  logic        clkn,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic        mem_gnt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_adr,
  output logic        k_we,
  output logic [3:0]  k_idx,
  output logic        mac_clr,
  output logic        mac_en,
  output logic [3:0]  tap_idx,
  output logic [3:0]  out_x,
  output logic [3:0]  out_y,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LDK, S_CLR, S_TAP, S_WAIT, S_WR, S_DONE
  } state_t;

  state_t      r_state, w_state;
  logic [3:0]  r_k, r_t, r_x, r_y;
  logic [3:0]  w_k, w_t, w_x, w_y;
  logic        w_acc;
  logic [11:0] w_adr;

  logic        r_mem_req, r_mem_we, r_k_we, r_mac_clr, r_mac_en, r_busy, r_done;
  logic [11:0] r_mem_adr;
  logic [3:0]  r_k_idx, r_tap_idx;

  function automatic logic [11:0] f_tap_adr(input logic [3:0] x, input logic [3:0] y,
                                            input logic [3:0] t);
    logic [3:0] ky;
    logic [3:0] kx;
    ky = t / 4'd3;
    kx = t % 4'd3;
    return IBASE + 12'((int'(y) + int'(ky)) * IMG_W + int'(x) + int'(kx));
  endfunction

  assign w_acc = r_mem_req & mem_gnt;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_state = r_state;
    w_k     = r_k;
    w_t     = r_t;
    w_x     = r_x;
    w_y     = r_y;
    case (r_state)
      S_IDLE: if (start) begin
        w_state = S_LDK;
        w_k = '0; w_t = '0; w_x = '0; w_y = '0;
      end
      S_LDK: if (w_acc) begin
        if (r_k == 4'd8) begin
          w_state = S_CLR;
          w_k     = '0;
        end else begin
          w_k = r_k + 4'd1;
        end
      end
      S_CLR: begin
        w_state = S_TAP;
        w_t     = '0;
      end
      S_TAP: if (w_acc) begin
        if (r_t == 4'd8) begin
          w_state = S_WAIT;
          w_t     = '0;
        end else begin
          w_t = r_t + 4'd1;
        end
      end
      S_WAIT: w_state = S_WR;
      S_WR: if (w_acc) begin
        if (r_x == 4'(IMG_W - 3)) begin
          w_x = '0;
          if (r_y == 4'(IMG_H - 3)) begin
            w_state = S_DONE;
            w_y     = '0;
          end else begin
            w_state = S_CLR;
            w_y     = r_y + 4'd1;
          end
        end else begin
          w_state = S_CLR;
          w_x     = r_x + 4'd1;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    // Abort overrides every transition, including a start seen in IDLE.
    if (abort) begin
      w_state = S_IDLE;
      w_k = '0; w_t = '0; w_x = '0; w_y = '0;
    end
  end

  always_comb begin
    w_adr = '0;
    case (w_state)
      S_LDK:   w_adr = KBASE + {8'd0, w_k};
      S_TAP:   w_adr = f_tap_adr(w_x, w_y, w_t);
      S_WR:    w_adr = OBASE + 12'(int'(w_y) * (IMG_W - 2) + int'(w_x));
      default: w_adr = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clkn or posedge rstn) begin
    if (rstn) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_t       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_adr <= '0;
      r_k_we    <= 1'b0;
      r_k_idx   <= '0;
      r_mac_clr <= 1'b0;
      r_mac_en  <= 1'b0;
      r_tap_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_k       <= w_k;
      r_t       <= w_t;
      r_x       <= w_x;
      r_y       <= w_y;
      r_mem_req <= (w_state == S_LDK) || (w_state == S_TAP) || (w_state == S_WR);
      r_mem_we  <= (w_state == S_WR);
      r_mem_adr <= w_adr;
      r_mac_clr <= (w_state == S_CLR);
      r_busy    <= (w_state != S_IDLE);
      r_done    <= (w_state == S_DONE);
      // Read data returns one cycle after acceptance; abort drops the pending strobe.
      r_k_we    <= !abort && (r_state == S_LDK) && w_acc;
      r_k_idx   <= (!abort && (r_state == S_LDK) && w_acc) ? r_k : 4'd0;
      r_mac_en  <= !abort && (r_state == S_TAP) && w_acc;
      r_tap_idx <= (!abort && (r_state == S_TAP) && w_acc) ? r_t : 4'd0;
    end
  end

  assign mem_req = r_mem_req;
  assign mem_we  = r_mem_we;
  assign mem_adr = r_mem_adr;
  assign k_we    = r_k_we;
  assign k_idx   = r_k_idx;
  assign mac_clr = r_mac_clr;
  assign mac_en  = r_mac_en;
  assign tap_idx = r_tap_idx;
  assign out_x   = r_x;
  assign out_y   = r_y;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_cnn_conv_sched.sv
// Self-checking bench for cnn_conv_sched: memory + MAC model, access scoreboard,
// directed runs with tied, random and held grant, abort and async reset.
module tb_cnn_conv_sched;
  localparam int          W       = 16;
  localparam int          H       = 16;
  localparam int          OW      = W - 2;
  localparam int          OH      = H - 2;
  localparam int          NPIX    = OW * OH;
  localparam int          CYC_NOM = 9 + NPIX * 12;
  localparam logic [11:0] KB      = 12'h000;
  localparam logic [11:0] IB      = 12'h100;
  localparam logic [11:0] OB      = 12'h200;

  logic        clkn = 1'b0, rstn = 1'b1, start = 1'b0, abort = 1'b0, mem_gnt = 1'b1;
  logic        mem_req, mem_we, k_we, mac_clr, mac_en, busy, done;
  logic [11:0] mem_adr;
  logic [3:0]  k_idx, tap_idx, out_x, out_y;
  logic [34:0] w_outs;

  assign w_outs = {mem_req, mem_we, mem_adr, k_we, k_idx, mac_clr, mac_en, tap_idx,
                   out_x, out_y, busy, done};

  always #5 clkn = ~clkn;

  cnn_conv_sched dut (
    .clkn(clkn), .rstn(rstn), .start(start), .abort(abort), .mem_gnt(mem_gnt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .k_we(k_we), .k_idx(k_idx),
    .mac_clr(mac_clr), .mac_en(mac_en), .tap_idx(tap_idx), .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [11:0] adr;
    logic        we;
    int          kind;   // 0 kernel read, 1 tap read, 2 result write
    int          idx;
  } acc_t;

  acc_t q[$];
  int   n_tests = 0, n_fail = 0;
  int   mem[4096];
  int   kern_ref[9];
  int   img_ref[W*H];
  int   kern_m[9];
  int   gnt_mode = 0;
  logic man_gnt = 1'b1;
  int   stalls = 0, mac_cnt = 0, acc_v = 0, rd_v = 0, pend_idx = 0;
  logic pend_k = 1'b0, pend_m = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input bit ones);
    for (int i = 0; i < 9; i++) begin
      kern_ref[i]         = i + 1;
      mem[int'(KB) + i]   = i + 1;
    end
    for (int i = 0; i < W*H; i++) begin
      img_ref[i]          = ones ? 1 : (i * 5 + 3) % 11;
      mem[int'(IB) + i]   = img_ref[i];
    end
    for (int i = 0; i < NPIX; i++) mem[int'(OB) + i] = 32'hdead;
  endtask

  task automatic push_exp();
    acc_t e;
    q.delete();
    for (int k = 0; k < 9; k++) begin
      e.adr = KB + 12'(k); e.we = 1'b0; e.kind = 0; e.idx = k;
      q.push_back(e);
    end
    for (int y = 0; y < OH; y++) begin
      for (int x = 0; x < OW; x++) begin
        for (int t = 0; t < 9; t++) begin
          e.adr = IB + 12'((y + t / 3) * W + x + t % 3); e.we = 1'b0; e.kind = 1; e.idx = t;
          q.push_back(e);
        end
        e.adr = OB + 12'(y * OW + x); e.we = 1'b1; e.kind = 2; e.idx = 0;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_mem();
    int exp_v;
    for (int y = 0; y < OH; y++) begin
      for (int x = 0; x < OW; x++) begin
        exp_v = 0;
        for (int t = 0; t < 9; t++) exp_v += img_ref[(y + t / 3) * W + x + t % 3] * kern_ref[t];
        chk($sformatf("out[%0d,%0d]", y, x), mem[int'(OB) + y * OW + x], exp_v);
      end
    end
  endtask

  task automatic kick();
    push_exp();
    start = 1'b1;
    @(posedge clkn); #1;
    start = 1'b0;
    chk("first_req", {mem_req, mem_we, mem_adr, busy}, {1'b1, 1'b0, KB, 1'b1});
  endtask

  task automatic wait_done(input int pulse_at, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 6000) begin
      @(posedge clkn); #1;
      cyc++;
      start = (cyc == pulse_at);
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    @(posedge clkn); #1;
    chk("done_one_cycle", {done, busy}, 2'b00);
    chk("all_accesses", q.size(), 0);
  endtask

  // Grant driver: tied high, 30% random drop, or manual.
  initial forever begin
    @(posedge clkn); #2;
    case (gnt_mode)
      0:       mem_gnt = 1'b1;
      1:       mem_gnt = ($urandom_range(99) >= 30);
      default: mem_gnt = man_gnt;
    endcase
  end

  // Monitor: memory with 1-cycle read latency, MAC model, access scoreboard.
  initial begin
    acc_t e;
    forever begin
      @(negedge clkn);
      if (rstn) begin
        q.delete();
        pend_k = 1'b0; pend_m = 1'b0; mac_cnt = 0;
      end else begin
        chk("k_we", k_we, pend_k);
        if (pend_k) chk("k_idx", k_idx, pend_idx);
        chk("mac_en", mac_en, pend_m);
        if (pend_m) chk("tap_idx", tap_idx, pend_idx);
        if (mem_we) chk("wr_overlaps_mac", mac_en, 0);
        if (k_we) kern_m[k_idx] = rd_v;
        if (mac_clr) begin acc_v = 0; mac_cnt = 0; end
        if (mac_en) begin acc_v += rd_v * kern_m[tap_idx]; mac_cnt++; end
        pend_k = 1'b0; pend_m = 1'b0;
        if (mem_req && !mem_gnt) stalls++;
        if (mem_req && mem_gnt) begin
          if (abort) q.delete();
          else begin
            chk("access_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
              e = q.pop_front();
              chk("adr", mem_adr, e.adr);
              chk("we", mem_we, e.we);
              if (e.we) begin
                chk("mac_per_px", mac_cnt, 9);
                mem[mem_adr] = acc_v;
              end else begin
                rd_v     = mem[mem_adr];
                pend_k   = (e.kind == 0);
                pend_m   = (e.kind == 1);
                pend_idx = e.idx;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    bit found;
    rstn = 1'b1;
    load_mem(1'b1);
    repeat (3) @(posedge clkn);
    #1 chk("reset_outputs", w_outs, 0);
    rstn = 1'b0;
    @(posedge clkn); #1;
    chk("idle_after_reset", w_outs, 0);

    start = 1'b1; abort = 1'b1;
    @(posedge clkn); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", {busy, mem_req}, 2'b00);

    // All-ones image, gnt tied high.
    gnt_mode = 0;
    kick();
    wait_done(-1, cyc);
    chk("cycles_gnt1", cyc, CYC_NOM);
    check_mem();

    // Patterned image, random grant drops.
    load_mem(1'b0);
    gnt_mode = 1;
    stalls   = 0;
    kick();
    wait_done(-1, cyc);
    chk("cycles_rand", cyc, CYC_NOM + stalls);
    check_mem();

    // Async reset in LDK: outputs clear before the next edge.
    gnt_mode = 0;
    load_mem(1'b0);
    kick();
    repeat (3) @(posedge clkn);
    #3 rstn = 1'b1;
    #1 chk("async_reset", w_outs, 0);
    @(posedge clkn); #1;
    rstn = 1'b0;
    chk("idle_after_async", w_outs, 0);

    // Start pulsed while busy is ignored.
    load_mem(1'b0);
    kick();
    wait_done(100, cyc);
    chk("cycles_start_busy", cyc, CYC_NOM);
    check_mem();

    // Grant held low for 5 cycles of the first write.
    load_mem(1'b0);
    gnt_mode = 2;
    man_gnt  = 1'b1;
    kick();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clkn); #1;
      if (mem_we) found = 1'b1;
    end
    chk("wr_reached", found, 1);
    man_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("wr_hold", {mem_req, mem_we, mem_adr, out_x}, {1'b1, 1'b1, OB, 4'd0});
      @(posedge clkn); #1;
    end
    man_gnt = 1'b1;
    chk("wr_hold_last", {mem_req, mem_we, mem_adr, out_x}, {1'b1, 1'b1, OB, 4'd0});
    @(posedge clkn); #1;
    chk("wr_accept", {mac_clr, mem_req, out_x}, {1'b1, 1'b0, 4'd1});

    // Abort during TAP of pixel x=3, y=7.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clkn); #1;
      if (out_x == 4'd3 && out_y == 4'd7 && mem_req && !mem_we && mac_en) found = 1'b1;
    end
    chk("abort_point", found, 1);
    abort = 1'b1;
    @(posedge clkn); #1;
    abort = 1'b0;
    chk("abort_idle", {busy, done, mem_req, mac_en, mac_clr}, 5'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clkn); #1;
      chk("after_abort", {mac_en, k_we, done, busy}, 4'b0);
    end

    // Restart after abort completes normally.
    gnt_mode = 0;
    load_mem(1'b0);
    kick();
    wait_done(-1, cyc);
    chk("cycles_restart", cyc, CYC_NOM);
    check_mem();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_conv_sched.md
# cnn_conv_sched

Convolution scheduler for the CNN_16 core. It sequences a 3x3 valid convolution over the 16x16 image held in shared data memory. First it loads the nine kernel words into the kernel register file, then it walks every output pixel: it issues the nine tap reads, strobes the MAC datapath, and writes each result back to memory. It sits between the CPU's CONV instruction decode and the memory arbiter, and requests memory through the same grant path as the CPU.

## Interface
- IMG_W, 16, image width in words
- IMG_H, 16, image height in words
- KBASE, 12'h000, kernel base address (9 words, row-major)
- IBASE, 12'h100, image base address (row-major)
- OBASE, 12'h200, output base address ((IMG_W-2)*(IMG_H-2) words, row-major)

Ports (one clock; reset is asynchronous and active-high):
- clkn  in  1  clock, rising edge
- rstn  in  1  asynchronous reset, active-high
- start  in  1  begin convolution; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE, no done
- mem_gnt  in  1  arbiter grant; a request is accepted on a cycle with mem_req&&mem_gnt
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write of MAC result, 0 = read
- mem_adr  out  12  access address
- k_we  out  1  kernel register write strobe (read data valid this cycle)
- k_idx  out  4  kernel register index 0..8
- mac_clr  out  1  clear accumulator
- mac_en  out  1  multiply-accumulate the read data with kernel[tap_idx]
- tap_idx  out  4  tap index 0..8 for mac_en
- out_x, out_y  out  4 each  current output coordinate
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at completion

## Operation
- States: IDLE, LDK, CLR, TAP, WAIT, WR, DONE.
- IDLE: all strobes low. On start, go to LDK and clear the counters.
- LDK: mem_req=1, mem_we=0, mem_adr=KBASE+k. k advances on acceptance. After the acceptance of k=8, go to CLR.
- CLR: mac_clr=1 for one cycle, no request. Go to TAP with t=0.
- TAP: mem_req=1, mem_adr=IBASE+(out_y+ky)*IMG_W+(out_x+kx), where ky=t/3 and kx=t%3. t advances on acceptance. After the acceptance of t=8, go to WAIT.
- WAIT: one cycle for the last read's data. Go to WR.
- WR: mem_req=1, mem_we=1, mem_adr=OBASE+out_y*(IMG_W-2)+out_x. Hold until accepted.
  - On acceptance, advance out_x. When out_x wraps past IMG_W-3, clear out_x and advance out_y.
  - After the last pixel (out_y=IMG_H-3, out_x=IMG_W-3), go to DONE. Otherwise go to CLR.
- DONE: done=1 for one cycle, busy=1. Go to IDLE.
- Read latency is fixed at 1 cycle:
  - k_we/k_idx follow a kernel read acceptance by exactly 1 cycle.
  - mac_en/tap_idx follow a tap read acceptance by exactly 1 cycle.
- Gnt low: the address and counters hold, and the data strobes show a bubble (low) one cycle later. No tap is skipped or duplicated.
- The last kernel k_we lands in the CLR cycle. The last mac_en lands in the WAIT cycle. WR never overlaps mac_en.
- Edge cases:
  - start while busy is ignored.
  - abort has priority over all transitions: next state IDLE, counters cleared, no done pulse, and any pending k_we/mac_en is suppressed.
  - abort and start together in IDLE: stay in IDLE.

## Timing
- Reset values: every output is 0; state is IDLE.
- Reset is asynchronous. Asserting it mid-run drops every output to 0 immediately, without waiting for a clock edge.
- With mem_gnt tied high, cycles from the start edge to the done pulse are 9 (LDK) + 196×12 (CLR 1 + TAP 9 + WAIT 1 + WR 1) = 2361; done is high in cycle 2362.
- Each cycle of mem_gnt low during a request adds exactly one cycle.
- mem_adr and mem_we are stable while mem_req is high and mem_gnt is low.

## Test plan
- Reset, then start with gnt=1:
  - First request is adr 000, k_we idx0 one cycle later.
  - First tap adrs are 100,101,102,110,111,112,120,121,122.
  - First write is adr 200.
  - Last write is adr 2C3; done 2361 cycles after start.
- Image all 1.0 and kernel 0.1..0.9: the reference model checks all 196 written words equal the kernel sum (4.5 in fp16). The scoreboard also checks the sequence of (tap_idx, adr) pairs.
- Random gnt at a 30% drop rate: no tap is duplicated or skipped, mac_en count per output is 9, and the final memory image matches the gnt=1 run.
- gnt held low during WR for 5 cycles: adr and we are stable, and out_x does not advance until acceptance.
- Abort in TAP of pixel (3,7):
  - Next cycle: IDLE, busy=0, no done, no further mac_en.
  - A restart completes normally.
- Async rstn mid-LDK: outputs are 0 before the next clkn edge. start pulsed while busy has no effect on the 2361-cycle count.
